// File: rtl/ram_sdp_pkg.sv
// ram_sdp_pkg: shared constants and parameter-check helpers for the accumulating SDP RAM
package ram_sdp_pkg;
  localparam int COLL_READ_OLD = 0;
  localparam int COLL_BYPASS = 1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic bit depth_fits(input int depth, input int addr_w);
    return depth >= 1 && clog2(depth) <= addr_w;
  endfunction
endpackage

// File: rtl/ram_sdp_accum_param_if.sv
// ram_sdp_accum_param_if: write/read/output bundle of the accumulating SDP RAM
interface ram_sdp_accum_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic we;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic re;
  logic [ADDR_W-1:0] read_addr;
  logic out_en;
  logic [DATA_W-1:0] dout;
  logic dout_valid;
  logic collision;
  modport master (output we, write_addr, a, b, re, read_addr, out_en, input dout, dout_valid, collision);
  modport slave (input we, write_addr, a, b, re, read_addr, out_en, output dout, dout_valid, collision);
endinterface

// File: rtl/ram_sdp_core.sv
// ram_sdp_core: zero-initialised storage array, one write port and one synchronous read port
module ram_sdp_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH = 512
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  // read-before-write on a shared address yields the old word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/ram_sdp_accum_param.sv
// ram_sdp_accum_param: SDP RAM with registered a+b write pre-adder, collision policy and gated output stage
module ram_sdp_accum_param
  import ram_sdp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH = 512,
  parameter int ACCUM = 1,
  parameter int OUT_REG = 1,
  parameter int COLL_MODE = 0
) (
  input logic clk,
  input logic reset,
  ram_sdp_accum_param_if.slave bus
);
  if (!depth_fits(DEPTH, ADDR_W)) begin : g_depth_chk
    $error("DEPTH %0d does not fit in ADDR_W %0d", DEPTH, ADDR_W);
  end
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  logic wv, rvalid, rd_zero, byp, collision_r;
  logic rd_fire, hit, rd_in, wr_in;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd, byp_d, q, rdata;
  always_comb begin
    rd_fire = bus.re && (OUT_REG != 0 || bus.out_en);
    hit = bus.re && wv && wa == bus.read_addr;
    rd_in = {1'b0, bus.read_addr} < LIMIT;
    wr_in = {1'b0, wa} < LIMIT;
    rdata = rd_zero ? '0 : byp ? byp_d : q;
  end
  ram_sdp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_core (
    .clk(clk),
    .we(wv && wr_in),
    .waddr(wa),
    .wdata(wd),
    .re(rd_fire && rd_in),
    .raddr(bus.read_addr),
    .q(q)
  );
  // the core output has no reset, so rd_zero masks it after reset and for out-of-range reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wv <= 1'b0;
      wa <= '0;
      wd <= '0;
      rvalid <= 1'b0;
      collision_r <= 1'b0;
      rd_zero <= 1'b1;
      byp <= 1'b0;
      byp_d <= '0;
    end else begin
      wv <= bus.we;
      wa <= bus.write_addr;
      wd <= ACCUM != 0 ? bus.a + bus.b : bus.a;
      rvalid <= rd_fire;
      collision_r <= hit;
      if (rd_fire) begin
        rd_zero <= !rd_in;
        byp <= COLL_MODE == COLL_BYPASS && hit;
        byp_d <= wd;
      end
    end
  end
  assign bus.collision = collision_r;
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] dout_q;
    logic dv_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_q <= '0;
        dv_q <= 1'b0;
      end else begin
        dv_q <= rvalid && bus.out_en;
        if (rvalid && bus.out_en) dout_q <= rdata;
      end
    end
    assign bus.dout = dout_q;
    assign bus.dout_valid = dv_q;
  end else begin : g_direct
    assign bus.dout = rdata;
    assign bus.dout_valid = rvalid;
  end
endmodule

// File: tb/tb_ram_sdp_accum_param.sv
// tb_ram_sdp_accum_param: directed plus random checks of two configurations against a reference model
module tb_ram_sdp_accum_param;
  localparam int DW = 32;
  localparam int AW = 9;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic we = 1'b0, re = 1'b0, oe = 1'b1;
  logic [AW-1:0] wad = '0, rad = '0;
  logic [DW-1:0] a = '0, b = '0;
  ram_sdp_accum_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  ram_sdp_accum_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  assign bus0.we = we;
  assign bus0.write_addr = wad;
  assign bus0.a = a;
  assign bus0.b = b;
  assign bus0.re = re;
  assign bus0.read_addr = rad;
  assign bus0.out_en = oe;
  assign bus1.we = we;
  assign bus1.write_addr = wad;
  assign bus1.a = a;
  assign bus1.b = b;
  assign bus1.re = re;
  assign bus1.read_addr = rad;
  assign bus1.out_en = oe;
  ram_sdp_accum_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(500), .ACCUM(1), .OUT_REG(1), .COLL_MODE(0)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0.slave));
  ram_sdp_accum_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(512), .ACCUM(0), .OUT_REG(0), .COLL_MODE(1)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1.slave));
  int dep[2] = '{500, 512};
  int oreg[2] = '{1, 0};
  int cm[2] = '{0, 1};
  logic [DW-1:0] mm [2][512];
  logic pv;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd[2];
  logic [DW-1:0] rd_e[2], do_e[2];
  logic rv_e[2], dv_e[2], co_e[2];
  int vecs = 0, errs = 0;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    pv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_e[i] = '0; do_e[i] = '0; rv_e[i] = 1'b0; dv_e[i] = 1'b0; co_e[i] = 1'b0;
    end
  endtask
  // a read on the commit edge sees the old word, unless that config forwards the word being written
  task automatic model_edge();
    logic [DW-1:0] v;
    logic fire, hit;
    for (int i = 0; i < 2; i++) begin
      fire = re && (oreg[i] != 0 || oe);
      hit = re && pv && pa == rad;
      v = (int'(rad) >= dep[i]) ? '0 : (cm[i] != 0 && hit) ? pd[i] : mm[i][rad];
      if (oreg[i] != 0) begin
        if (rv_e[i] && oe) do_e[i] = rd_e[i];
        dv_e[i] = rv_e[i] && oe;
      end
      if (fire) rd_e[i] = v;
      rv_e[i] = fire;
      co_e[i] = hit;
      if (oreg[i] == 0) begin
        do_e[i] = rd_e[i];
        dv_e[i] = rv_e[i];
      end
      if (pv && int'(pa) < dep[i]) mm[i][pa] = pd[i];
    end
    pv = we; pa = wad; pd[0] = a + b; pd[1] = a;
  endtask
  task automatic check_all();
    chk("dout0", bus0.dout, do_e[0]);
    chk("dout_valid0", DW'(bus0.dout_valid), DW'(dv_e[0]));
    chk("collision0", DW'(bus0.collision), DW'(co_e[0]));
    chk("dout1", bus1.dout, do_e[1]);
    chk("dout_valid1", DW'(bus1.dout_valid), DW'(dv_e[1]));
    chk("collision1", DW'(bus1.collision), DW'(co_e[1]));
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1 check_all();
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) for (int j = 0; j < 512; j++) mm[i][j] = '0;
    model_reset();
    #1 rst_n = 1'b0;
    cyc(2);
    chk("rst_dout0", bus0.dout, '0);
    chk("rst_dv1", DW'(bus1.dout_valid), '0);
    rst_n = 1'b1;
    cyc(1);
    // write 0x10+0x22 to 5, read back after three idle cycles
    we = 1'b1; wad = 9'd5; a = 32'h10; b = 32'h22;
    cyc(1);
    we = 1'b0;
    cyc(3);
    re = 1'b1; rad = 9'd5;
    cyc(1);
    re = 1'b0;
    chk("wr_dv0_early", DW'(bus0.dout_valid), '0);
    chk("wr_dout1", bus1.dout, 32'h10);
    cyc(1);
    chk("wr_dout0", bus0.dout, 32'h32);
    chk("wr_dv0", DW'(bus0.dout_valid), 32'h1);
    // adder wrap on the last in-range word of the 500-deep config
    we = 1'b1; wad = 9'd499; a = 32'hFFFF_FFFF; b = 32'h2;
    cyc(1);
    we = 1'b0;
    cyc(3);
    re = 1'b1; rad = 9'd499;
    cyc(1);
    re = 1'b0;
    chk("wrap_dout1", bus1.dout, 32'hFFFF_FFFF);
    cyc(1);
    chk("wrap_dout0", bus0.dout, 32'h1);
    // collision: 0xAA at 7, then write 0x55 and read 7 on its commit edge
    we = 1'b1; wad = 9'd7; a = 32'hAA; b = '0;
    cyc(1);
    we = 1'b0;
    cyc(2);
    we = 1'b1; a = 32'h55;
    cyc(1);
    we = 1'b0; re = 1'b1; rad = 9'd7;
    cyc(1);
    re = 1'b0;
    chk("coll_flag0", DW'(bus0.collision), 32'h1);
    chk("coll_flag1", DW'(bus1.collision), 32'h1);
    chk("coll_bypass1", bus1.dout, 32'h55);
    cyc(1);
    chk("coll_drop0", DW'(bus0.collision), '0);
    chk("coll_old0", bus0.dout, 32'hAA);
    cyc(1);
    re = 1'b1;
    cyc(1);
    re = 1'b0;
    chk("coll_later1", bus1.dout, 32'h55);
    cyc(1);
    chk("coll_later0", bus0.dout, 32'h55);
    // out_en low: read of 5 must be discarded by both configs
    oe = 1'b0; re = 1'b1; rad = 9'd5;
    cyc(1);
    re = 1'b0;
    cyc(3);
    chk("oe_hold0", bus0.dout, 32'h55);
    chk("oe_hold1", bus1.dout, 32'h55);
    oe = 1'b1; re = 1'b1;
    cyc(1);
    re = 1'b0;
    cyc(1);
    chk("oe_upd0", bus0.dout, 32'h32);
    chk("oe_upd1", bus1.dout, 32'h10);
    // asynchronous reset between capture and commit of a write to 3
    we = 1'b1; wad = 9'd3; a = 32'h99; b = '0;
    cyc(1);
    we = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_dout0", bus0.dout, '0);
    chk("arst_dout1", bus1.dout, '0);
    chk("arst_dv0", DW'(bus0.dout_valid), '0);
    chk("arst_coll1", DW'(bus1.collision), '0);
    cyc(2);
    rst_n = 1'b1;
    re = 1'b1; rad = 9'd3;
    cyc(1);
    re = 1'b0;
    chk("arst_rd1", bus1.dout, '0);
    chk("arst_rv1", DW'(bus1.dout_valid), 32'h1);
    cyc(1);
    chk("arst_rd0", bus0.dout, '0);
    // out of range for the 500-deep config, in range for the 512-deep one
    we = 1'b1; wad = 9'd505; a = 32'h1234; b = '0;
    cyc(1);
    we = 1'b0;
    cyc(2);
    re = 1'b1; rad = 9'd505;
    cyc(1);
    re = 1'b0;
    chk("oob_dout1", bus1.dout, 32'h1234);
    cyc(1);
    chk("oob_dout0", bus0.dout, '0);
    chk("oob_dv0", DW'(bus0.dout_valid), 32'h1);
    re = 1'b1; rad = 9'd5;
    cyc(1);
    re = 1'b0;
    cyc(1);
    chk("oob_alias0", bus0.dout, 32'h32);
    for (int k = 0; k < 400; k++) begin
      we = 1'($urandom);
      re = 1'($urandom);
      oe = ($urandom % 4) != 0;
      wad = ($urandom % 4 == 0) ? AW'(495 + $urandom % 17) : AW'($urandom % 12);
      rad = ($urandom % 4 == 0) ? AW'(495 + $urandom % 17) : AW'($urandom % 12);
      a = $urandom;
      b = $urandom;
      cyc(1);
    end
    we = 1'b0; re = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
